// File: rtl/proc_pkg.sv
// proc_pkg: opcode constants, instruction field positions and the fetch state encoding
// shared by the processor front end.
package proc_pkg;
    localparam int OP_MSB      = 31;
    localparam int OP_LSB      = 27;
    localparam int RDST_MSB    = 26;
    localparam int RDST_LSB    = 22;
    localparam int RSRC1_MSB   = 21;
    localparam int RSRC1_LSB   = 17;
    localparam int IM_MODE_BIT = 16;
    localparam int RSRC2_MSB   = 15;
    localparam int RSRC2_LSB   = 11;
    localparam int ISRC_MSB    = 15;
    localparam int ISRC_LSB    = 0;

    localparam logic [4:0] OP_MOV   = 5'd0;
    localparam logic [4:0] OP_ADD   = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_AND   = 5'd3;
    localparam logic [4:0] OP_OR    = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_JMP   = 5'd6;
    localparam logic [4:0] OP_JZ    = 5'd7;
    localparam logic [4:0] OP_LOAD  = 5'd8;
    localparam logic [4:0] OP_STORE = 5'd9;
    localparam logic [4:0] OP_HALT  = 5'd31;

    typedef enum logic [1:0] {
        FS_REQ,
        FS_WAIT,
        FS_HOLD,
        FS_HALT
    } fetch_state_e;

    function automatic logic is_halt(input logic [31:0] w);
        return w[OP_MSB:OP_LSB] == OP_HALT;
    endfunction
endpackage

// File: rtl/instr_fetch_buf.sv
// instr_fetch_buf: 2-entry FIFO with flush, used as the prefetch instruction buffer
// when instr_fetch is built with IFETCH_PREFETCH_EN.
module instr_fetch_buf #(
    parameter int W = 40
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic [1:0]   count_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_q, rd_q;
    logic [1:0]   count_q;

    assign data_o  = mem_q[rd_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_i) mem_q[wr_q] <= data_i;
            wr_q    <= wr_q ^ push_i;
            rd_q    <= rd_q ^ pop_i;
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage with one-cycle program memory, jump redirect and HALT/resume.
// Defining IFETCH_PREFETCH_EN replaces the single HOLD register with a 2-entry prefetch buffer.
module instr_fetch
    import proc_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               sys_rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_data,
    output logic [PC_W-1:0]    ir_pc,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               resume,
    output logic               halted
);
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    logic [PC_W-1:0] pc_q, pc_d;

    assign imem_addr = pc_q;

`ifdef IFETCH_PREFETCH_EN
    logic                    inflight_q, inflight_d;
    logic                    stop_q, stop_d;
    logic                    halted_q, halted_d;
    logic                    push, pop, halt_wr;
    logic [1:0]              count;
    logic [PC_W+INSTR_W-1:0] head;

    assign push     = inflight_q && !redirect_valid;
    assign halt_wr  = push && is_halt(imem_rdata);
    assign pop      = ir_valid && ir_ready && !redirect_valid;
    assign ir_valid = count != 2'd0;
    assign {ir_pc, ir_data} = head;
    assign halted   = halted_q;
    // the in-flight read already owns a buffer slot; the slot freed by this cycle's pop is reusable
    assign imem_req = !sys_rst && !redirect_valid && !stop_q && !halt_wr &&
                      (count + {1'b0, inflight_q} - {1'b0, pop}) < 2'd2;

    // pc advances on every request, so the in-flight word was fetched from pc_q - 1
    instr_fetch_buf #(.W(PC_W + INSTR_W)) u_buf (
        .clk_i   (clk),
        .rst_i   (sys_rst),
        .flush_i (redirect_valid),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({pc_q - PC_ONE, imem_rdata}),
        .data_o  (head),
        .count_o (count)
    );

    always_comb begin
        pc_d       = imem_req ? pc_q + PC_ONE : pc_q;
        inflight_d = imem_req;
        stop_d     = stop_q || halt_wr;
        halted_d   = halted_q || (pop && is_halt(ir_data));
        if (halted_q && resume) begin
            stop_d   = 1'b0;
            halted_d = 1'b0;
        end
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
            stop_d     = 1'b0;
            halted_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            pc_q       <= '0;
            inflight_q <= 1'b0;
            stop_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            stop_q     <= stop_d;
            halted_q   <= halted_d;
        end
    end
`else
    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] ir_data_q, ir_data_d;
    logic [PC_W-1:0]    ir_pc_q, ir_pc_d;

    assign imem_req = state_q == FS_REQ && !sys_rst;
    assign ir_valid = state_q == FS_HOLD;
    assign halted   = state_q == FS_HALT;
    assign ir_data  = ir_data_q;
    assign ir_pc    = ir_pc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_data_d = ir_data_q;
        ir_pc_d   = ir_pc_q;
        case (state_q)
            FS_REQ:  state_d = FS_WAIT;
            FS_WAIT: begin
                state_d   = FS_HOLD;
                ir_data_d = imem_rdata;
                ir_pc_d   = pc_q;
            end
            FS_HOLD: if (ir_ready) begin
                pc_d    = pc_q + PC_ONE;
                state_d = is_halt(ir_data_q) ? FS_HALT : FS_REQ;
            end
            FS_HALT: state_d = resume ? FS_REQ : FS_HALT;
            default: state_d = FS_REQ;
        endcase
        // leaving REQ/WAIT for REQ is what drops a response that is still on its way
        if (redirect_valid) begin
            state_d = FS_REQ;
            pc_d    = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q   <= FS_REQ;
            pc_q      <= '0;
            ir_data_q <= '0;
            ir_pc_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_data_q <= ir_data_d;
            ir_pc_q   <= ir_pc_d;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench; a program-order model of the fetch stream feeds an
// expected queue that a negedge monitor checks against every accepted instruction.
`timescale 1ns/1ps
module tb_instr_fetch;
    import proc_pkg::*;
`ifdef IFETCH_PREFETCH_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 3;
`endif
    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0, sys_rst = 1'b1, ir_ready = 1'b0, redirect_valid = 1'b0, resume = 1'b0;
    logic        imem_req, ir_valid, halted;
    logic [7:0]  imem_addr, ir_pc, redirect_pc = 8'h00;
    logic [31:0] imem_rdata = 32'h0, ir_data;
    logic [31:0] mem [256];

    ent_t        exp_q[$];
    int          acc_t[$];
    int          checks = 0, failures = 0, cyc = 0, acc_cnt = 0;
    logic        exp_halted = 1'b0, prev_v = 1'b0, prev_gone = 1'b0, acc, hacc;
    logic [7:0]  model_pc = 8'h00, prev_pc = 8'h00;
    logic [31:0] prev_d = 32'h0;
    ent_t        e;

    instr_fetch dut (
        .clk(clk), .sys_rst(sys_rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data),
        .ir_pc(ir_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .resume(resume), .halted(halted)
    );

    always #5 clk = ~clk;

    // program memory: data one cycle after the request, garbage otherwise
    always @(posedge clk) begin
        cyc        <= cyc + 1;
        imem_rdata <= imem_req ? mem[imem_addr] : $urandom;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // program order from start: consecutive words, wrapping, up to and including a HALT
    function automatic void refill(input logic [7:0] start);
        logic [7:0] a;
        a = start;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back({a, mem[a]});
            if (mem[a][31:27] == OP_HALT) break;
            a = a + 8'd1;
        end
    endfunction

    initial forever begin
        @(negedge clk);
        if (sys_rst) begin
            prev_v     = 1'b0;
            exp_halted = 1'b0;
            model_pc   = 8'h00;
            refill(8'h00);
        end else begin
            acc  = ir_valid && ir_ready && !redirect_valid;
            hacc = 1'b0;
            chk("halted", 32'(halted), 32'(exp_halted));
            if (prev_v && !prev_gone) begin
                chk("hold_valid", 32'(ir_valid), 32'd1);
                chk("hold_data", ir_data, prev_d);
                chk("hold_pc", 32'(ir_pc), 32'(prev_pc));
            end
`ifndef IFETCH_PREFETCH_EN
            if (imem_req && !redirect_valid) begin
                chk("req_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("imem_addr", 32'(imem_addr), 32'(exp_q[0].pc));
            end
`endif
            if (acc) begin
                chk("accept_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("ir_pc", 32'(ir_pc), 32'(e.pc));
                    chk("ir_data", ir_data, e.data);
                    hacc     = e.data[31:27] == OP_HALT;
                    model_pc = e.pc + 8'd1;
                    acc_cnt++;
                    acc_t.push_back(cyc);
                end
            end
            if (redirect_valid) begin
                model_pc = redirect_pc;
                refill(redirect_pc);
            end else if (resume && exp_halted) begin
                refill(model_pc);
            end
            exp_halted = redirect_valid ? 1'b0 : (resume && exp_halted) ? 1'b0 : hacc ? 1'b1 : exp_halted;
            prev_v    = ir_valid;
            prev_gone = acc || redirect_valid;
            prev_d    = ir_data;
            prev_pc   = ir_pc;
        end
    end

    task automatic check_reset_values();
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_ir_data", ir_data, 32'd0);
        chk("rst_ir_pc", 32'(ir_pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
    endtask

    task automatic release_check();
        int k = 0;
        sys_rst = 1'b0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                chk("req_after_rst", 32'(imem_req), 32'd1);
                chk("addr_after_rst", 32'(imem_addr), 32'd0);
            end
        end while (!ir_valid && k < 20);
        chk("first_valid_latency", k, 32'd3);
    endtask

    task automatic wait_acc(input int target, input int budget);
        int n = 0;
        while (acc_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("accept_count_reached", 32'(acc_cnt >= target), 32'd1);
    endtask

    task automatic pulse_redirect(input logic [7:0] target);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        ir_ready       = 1'b1;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, reqs, t;
        for (int i = 0; i < 256; i++) begin
            mem[i] = {5'($urandom_range(0, 30)), 27'($urandom)};
            if (i >= 'h40 && i < 'hF0 && $urandom_range(0, 11) == 0) mem[i][31:27] = OP_HALT;
        end
        for (int i = 0; i < 4; i++) mem[i] = 32'h1000_0001 + i;
        mem[4] = {OP_HALT, 27'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        ir_ready = 1'b1;
        release_check();

        wait_acc(5, 60);
        if (acc_t.size() >= 5)
            for (int i = 0; i < 4; i++) chk("accept_gap", acc_t[i+1] - acc_t[i], GAP);
        k = 0;
        while (!halted && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("halted_reached", 32'(halted), 32'd1);
        reqs = 0;
        repeat (5) begin
            @(negedge clk);
            if (imem_req) reqs++;
        end
        chk("halt_no_req", reqs, 32'd0);

        @(posedge clk); #1;
        ir_ready = 1'b0;
        resume   = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ir_valid && k < 20);
        chk("resume_valid", 32'(ir_valid), 32'd1);
        chk("resume_pc", 32'(ir_pc), 32'h05);

        reqs = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req) reqs++;
        end
`ifndef IFETCH_PREFETCH_EN
        chk("stall_no_req", reqs, 32'd0);
`endif
        chk("stall_pc", 32'(ir_pc), 32'h05);

        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h20;
        ir_ready       = 1'b1;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_req", 32'(imem_req), 32'd1);
        chk("redir_addr", 32'(imem_addr), 32'h20);
        @(negedge clk);
        chk("redir_valid_n2", 32'(ir_valid), 32'd0);
        @(negedge clk);
        chk("redir_valid_n3", 32'(ir_valid), 32'd1);
        chk("redir_pc", 32'(ir_pc), 32'h20);
        t = acc_cnt + 4;
        wait_acc(t, 40);

        pulse_redirect(8'hFD);
        k = 0;
        while (model_pc != 8'h02 && k < 40) begin
            @(posedge clk);
            k++;
        end
        chk("wrap_model_pc", 32'(model_pc), 32'h02);

        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!imem_req && k < 20);
        @(posedge clk); #1;
        sys_rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        release_check();
        t = acc_cnt + 3;
        wait_acc(t, 40);

        repeat (600) begin
            @(posedge clk); #1;
            ir_ready       = $urandom_range(0, 3) != 0;
            redirect_valid = $urandom_range(0, 19) == 0;
            redirect_pc    = 8'($urandom);
            resume         = $urandom_range(0, 5) == 0;
        end
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        resume         = 1'b0;
        ir_ready       = 1'b1;
        repeat (10) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the small 16/32-bit instruction processor. Reads 32-bit instruction words from a program memory with a fixed one-cycle read latency, holds the current instruction word, and hands it to the decode/execute stage over a valid/ready handshake. Handles jump redirects from execute and stops on the HALT opcode until resumed.

## Interface
- PC_W, 8, program-counter / instruction-memory address width
- INSTR_W, 32, instruction word width; fixed at 32 by the instruction format
- clk  in  1  system clock, all state on rising edge
- sys_rst  in  1  synchronous, active-high reset
- imem_req  out  1  read strobe to program memory
- imem_addr  out  PC_W  read address, valid when imem_req=1
- imem_rdata  in  INSTR_W  read data, valid exactly one cycle after the req cycle
- ir_valid  out  1  ir_data/ir_pc hold an instruction for execute
- ir_ready  in  1  execute accepts the instruction this cycle
- ir_data  out  INSTR_W  instruction word (op_type in [31:27])
- ir_pc  out  PC_W  address the instruction was fetched from
- redirect_valid  in  1  taken jump from execute, single-cycle pulse
- redirect_pc  in  PC_W  jump target
- resume  in  1  single-cycle pulse, leave HALT
- halted  out  1  fetch is stopped on a HALT instruction

## Operation
- States: REQ (drive imem_req, imem_addr=pc), WAIT (capture imem_rdata), HOLD (ir_valid=1 until ir_valid&ir_ready), HALT.
- REQ→WAIT always; WAIT→HOLD; HOLD→REQ on accept with pc<=pc+1; HOLD→HALT on accept when ir_data[31:27]==OP_HALT (pc<=pc+1, halted=1).
- HALT→REQ on resume; fetch continues at the address after the HALT instruction.
- pc wraps 2^PC_W-1 → 0 with no error.
- redirect_valid in any state: pc<=redirect_pc, ir_valid<=0, any in-flight memory response is discarded, state<=REQ, halted<=0. Redirect wins over accept, HALT detection and resume in the same cycle.
- resume outside HALT is ignored.
- An instruction presented (ir_valid=1) holds ir_data/ir_pc stable until accepted or flushed.

## Timing
- Reset values: imem_req=0, imem_addr=0, ir_valid=0, ir_data=0, ir_pc=0, halted=0, pc=0, state=REQ.
- First cycle after sys_rst drops: imem_req=1, imem_addr=0. Next cycle: data captured. Third cycle: ir_valid=1.
- Without prefetch, ir_ready held 1: one instruction every 3 cycles.
- Redirect asserted in cycle N: imem_req=1 with imem_addr=redirect_pc in cycle N+1; ir_valid at N+3.
- sys_rst mid-operation overrides everything, including an in-flight read; its response is dropped.

## Configuration
- IFETCH_PREFETCH_EN defined: 2-entry instruction buffer. A request is issued every cycle while (buffered + in-flight) < 2 and not stopped; sustained throughput 1 instruction/cycle with ir_ready=1 after a 2-cycle fill. HALT is detected at buffer write: no further requests issued; halted asserts when the HALT entry is accepted. Redirect flushes buffer and in-flight response.
- Undefined: single HOLD register, behaviour exactly as in Operation/Timing.

## Structure
- Shared package proc_pkg: opcode constants incl. OP_HALT, instruction field positions (op_type, rdst, rsrc1, im_mode, rsrc2, isrc), fetch state enum.
- Optional sub-module instr_fetch_buf (2-entry FIFO with flush), instantiated only under IFETCH_PREFETCH_EN.

## Test plan
- Reset, memory preloaded addr0..3 = 32'h1000_0001..04, ir_ready=1 → ir_pc 0,1,2,3 with matching ir_data in order, first ir_valid 3 cycles after reset release.
- ir_ready=0 for 10 cycles while ir_valid → ir_data/ir_pc stable, no new imem_req (prefetch: at most 2 outstanding).
- Redirect to 8'h20 while an instruction is held at pc 5 → held instruction dropped, next issued ir_pc=8'h20.
- HALT word (op_type=OP_HALT) at addr 4 → accepted, halted=1, no imem_req; resume → next ir_pc=5, halted=0.
- pc at 8'hFF accepted → next imem_addr=8'h00.
- Redirect and accept in same cycle, plus sys_rst during WAIT → redirect target wins; after reset all outputs at reset values and fetch restarts at addr 0.
